myproject_sdiv_26s_15ns_16_seq: RTL and testbench

Sequential signed-by-unsigned divider: the inverse of the 16s×15ns→26 product multiplier. It takes a 26-bit signed dividend and a 15-bit unsigned divisor, produces a 16-bit signed quotient truncated toward zero and a signed remainder, one quotient bit per clock. It sits in the dense/normalisation datapath wherever a fixed-point product must be rescaled by a runtime divisor. Ready/valid handshakes are used on both sides.

---
 rtl/myproject_div_pkg.sv | 29 ++
 rtl/myproject_div_sign_fix.sv | 64 ++++++
 rtl/myproject_sdiv_26s_15ns_16_seq.sv | 160 ++++++++++++++++
 tb/tb_myproject_sdiv_26s_15ns_16_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/myproject_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : myproject_div_pkg
// Description : Shared types and default widths for the sequential
//               signed-by-unsigned divider.
// Revision    : 1.0 - initial release
// ============================================================================
package myproject_div_pkg;

  localparam int DEF_DIVIDEND_WIDTH = 26;
  localparam int DEF_DIVISOR_WIDTH  = 15;
  localparam int DEF_QUOTIENT_WIDTH = 16;

  // Iteration counter must hold 0..DIVIDEND_WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DEF_CNT_WIDTH = cnt_width(DEF_DIVIDEND_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/myproject_div_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : myproject_div_sign_fix
// Description : Combinational sign restoration, overflow detection and
//               saturation/wrap select for the divider result.
//               Build macro: MYPROJECT_DIV_SAT_EN (clamp quotient on overflow).
// Revision    : 1.0 - initial release
// ============================================================================
module myproject_div_sign_fix
  import myproject_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH,
  parameter int QUOTIENT_WIDTH = DEF_QUOTIENT_WIDTH
) (
  input  logic [DIVIDEND_WIDTH-1:0] quo_mag_i,
  input  logic [DIVISOR_WIDTH-1:0]  rem_mag_i,
  input  logic                      neg_i,
  input  logic                      dbz_i,
  output logic [QUOTIENT_WIDTH-1:0] quo_o,
  output logic [DIVISOR_WIDTH:0]    rem_o,
  output logic                      ovf_o
);

  localparam int XW = DIVIDEND_WIDTH + 1;

  // Largest representable positive magnitude, and one more for the negative side.
  localparam logic [XW-1:0] POS_LIM = {{(XW-QUOTIENT_WIDTH+1){1'b0}}, {(QUOTIENT_WIDTH-1){1'b1}}};
  localparam logic [XW-1:0] NEG_LIM = POS_LIM + XW'(1);

  localparam logic [QUOTIENT_WIDTH-1:0] Q_MAX = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
  localparam logic [QUOTIENT_WIDTH-1:0] Q_MIN = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};

  logic [XW-1:0]             quo_ext;
  logic [XW-1:0]             quo_signed;
  logic [DIVISOR_WIDTH:0]    rem_ext;
  logic [QUOTIENT_WIDTH-1:0] quo_sat;
  logic                      mag_ovf;

  assign quo_ext    = {1'b0, quo_mag_i};
  assign quo_signed = neg_i ? (~quo_ext + XW'(1)) : quo_ext;
  assign rem_ext    = {1'b0, rem_mag_i};
  assign quo_sat    = neg_i ? Q_MIN : Q_MAX;
  assign mag_ovf    = neg_i ? (quo_ext > NEG_LIM) : (quo_ext > POS_LIM);

  // Select final quotient/remainder; divide-by-zero always yields the saturated value.
  always_comb begin
    quo_o = quo_signed[QUOTIENT_WIDTH-1:0];
    rem_o = neg_i ? (~rem_ext + (DIVISOR_WIDTH+1)'(1)) : rem_ext;
    ovf_o = mag_ovf;
`ifdef MYPROJECT_DIV_SAT_EN
    if (mag_ovf) begin
      quo_o = quo_sat;
    end
`endif
    if (dbz_i) begin
      quo_o = quo_sat;
      rem_o = '0;
      ovf_o = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/myproject_sdiv_26s_15ns_16_seq.sv
`default_nettype none
// ============================================================================
// Module      : myproject_sdiv_26s_15ns_16_seq
// Description : Sequential restoring divider, signed dividend by unsigned
//               divisor, one quotient bit per clock, ready/valid on both sides.
//               Build macro: MYPROJECT_DIV_SAT_EN (clamp quotient on overflow).
// Revision    : 1.0 - initial release
// ============================================================================
module myproject_sdiv_26s_15ns_16_seq
  import myproject_div_pkg::*;
#(
  parameter int ID             = 1,
  parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH,
  parameter int QUOTIENT_WIDTH = DEF_QUOTIENT_WIDTH
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      din_vld,
  output logic                      din_rdy,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      dout_vld,
  input  logic                      dout_rdy,
  output logic [QUOTIENT_WIDTH-1:0] dout,
  output logic [DIVISOR_WIDTH:0]    rem,
  output logic                      dbz,
  output logic                      ovf
);

  localparam int                CNT_W    = cnt_width(DIVIDEND_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIVIDEND_WIDTH - 1);

  // Instance tag carries no logic.
  logic [31:0] unused_id;
  assign unused_id = 32'(ID);

  div_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DIVIDEND_WIDTH-1:0] mag_q, mag_d;    // dividend magnitude, becomes quotient
  logic [DIVISOR_WIDTH-1:0]  part_q, part_d;  // partial remainder
  logic [DIVISOR_WIDTH-1:0]  div_q, div_d;
  logic                      neg_q, neg_d;
  logic                      zdiv_q, zdiv_d;
  logic [QUOTIENT_WIDTH-1:0] dout_q, dout_d;
  logic [DIVISOR_WIDTH:0]    rem_q, rem_d;
  logic                      dbz_q, dbz_d;
  logic                      ovf_q, ovf_d;

  logic [DIVISOR_WIDTH:0]    shift_w;
  logic                      ge_w;
  logic [QUOTIENT_WIDTH-1:0] fix_quo;
  logic [DIVISOR_WIDTH:0]    fix_rem;
  logic                      fix_ovf;

  assign shift_w = {part_q, mag_q[DIVIDEND_WIDTH-1]};
  assign ge_w    = (shift_w >= {1'b0, div_q});

  myproject_div_sign_fix #(
    .DIVIDEND_WIDTH (DIVIDEND_WIDTH),
    .DIVISOR_WIDTH  (DIVISOR_WIDTH),
    .QUOTIENT_WIDTH (QUOTIENT_WIDTH)
  ) u_sign_fix (
    .quo_mag_i (mag_q),
    .rem_mag_i (part_q),
    .neg_i     (neg_q),
    .dbz_i     (zdiv_q),
    .quo_o     (fix_quo),
    .rem_o     (fix_rem),
    .ovf_o     (fix_ovf)
  );

  // Next-state and datapath update; divide-by-zero also passes through FIX
  // so all result registration happens in a single place.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    part_d  = part_q;
    div_d   = div_q;
    neg_d   = neg_q;
    zdiv_d  = zdiv_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (din_vld) begin
          neg_d   = din0[DIVIDEND_WIDTH-1];
          mag_d   = din0[DIVIDEND_WIDTH-1] ? (~din0 + DIVIDEND_WIDTH'(1)) : din0;
          div_d   = din1;
          part_d  = '0;
          cnt_d   = '0;
          zdiv_d  = (din1 == '0);
          state_d = (din1 == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        mag_d  = {mag_q[DIVIDEND_WIDTH-2:0], ge_w};
        part_d = ge_w ? DIVISOR_WIDTH'(shift_w - {1'b0, div_q}) : shift_w[DIVISOR_WIDTH-1:0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        dout_d  = fix_quo;
        rem_d   = fix_rem;
        dbz_d   = zdiv_q;
        ovf_d   = fix_ovf;
        state_d = DONE;
      end
      DONE: begin
        if (dout_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      part_q  <= '0;
      div_q   <= '0;
      neg_q   <= 1'b0;
      zdiv_q  <= 1'b0;
      dout_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      part_q  <= part_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      zdiv_q  <= zdiv_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign din_rdy  = (state_q == IDLE);
  assign dout_vld = (state_q == DONE);
  assign dout     = dout_q;
  assign rem      = rem_q;
  assign dbz      = dbz_q;
  assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_myproject_sdiv_26s_15ns_16_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_myproject_sdiv_26s_15ns_16_seq
// Description : Directed self-checking bench for the sequential divider.
//               Build macro: MYPROJECT_DIV_SAT_EN selects expected overflow value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_myproject_sdiv_26s_15ns_16_seq;

  logic        clk = 1'b0;
  logic        ap_rst;
  logic        din_vld;
  logic        din_rdy;
  logic [25:0] din0;
  logic [14:0] din1;
  logic        dout_vld;
  logic        dout_rdy;
  logic [15:0] dout;
  logic [15:0] rem;
  logic        dbz;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  myproject_sdiv_26s_15ns_16_seq #(
    .ID             (1),
    .DIVIDEND_WIDTH (26),
    .DIVISOR_WIDTH  (15),
    .QUOTIENT_WIDTH (16)
  ) dut (
    .ap_clk   (clk),
    .ap_rst   (ap_rst),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .din0     (din0),
    .din1     (din1),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .dout     (dout),
    .rem      (rem),
    .dbz      (dbz),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Present operands for one edge, then count edges until dout_vld (bounded).
  task automatic run_op(input logic [25:0] a, input logic [14:0] b, output int lat);
    din0    = a;
    din1    = b;
    din_vld = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
    lat = 0;
    while (!dout_vld && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    dout_rdy = 1'b1;
    @(posedge clk); #1;
    dout_rdy = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (din_rdy !== 1'b1)  begin bad++; $display("FAIL reset_din_rdy got=%b want=1", din_rdy); end
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL reset_dout_vld got=%b want=0", dout_vld); end
    total++; if (dout !== 16'h0 || rem !== 16'h0) begin bad++; $display("FAIL reset_data got dout=%h rem=%h want 0 0", dout, rem); end
    total++; if (dbz !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL reset_flags got dbz=%b ovf=%b want 0 0", dbz, ovf); end
  endtask

  task automatic test_divide(input string name, input logic [25:0] a, input logic [14:0] b,
                             input int exp_lat, input logic [15:0] exp_q, input logic [15:0] exp_r,
                             input logic exp_dbz, input logic exp_ovf);
    int lat;
    run_op(a, b, lat);
    total++; if (lat !== exp_lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat); end
    total++; if (dout !== exp_q) begin bad++; $display("FAIL %s_dout got=%0d want=%0d", name, $signed(dout), $signed(exp_q)); end
    total++; if (rem !== exp_r) begin bad++; $display("FAIL %s_rem got=%0d want=%0d", name, $signed(rem), $signed(exp_r)); end
    total++; if (dbz !== exp_dbz || ovf !== exp_ovf) begin bad++; $display("FAIL %s_flags got dbz=%b ovf=%b want dbz=%b ovf=%b", name, dbz, ovf, exp_dbz, exp_ovf); end
    release_result();
    total++; if (din_rdy !== 1'b1 || dout_vld !== 1'b0) begin bad++; $display("FAIL %s_return got rdy=%b vld=%b want 1 0", name, din_rdy, dout_vld); end
  endtask

  task automatic test_overflow();
    logic [15:0] big, p32768, m32769;
`ifdef MYPROJECT_DIV_SAT_EN
    big = 16'h7FFF; p32768 = 16'h7FFF; m32769 = 16'h8000;
`else
    big = 16'hFFFF; p32768 = 16'h8000; m32769 = 16'h7FFF;
`endif
    test_divide("ovf_max",    26'd33554431,  15'd1, 27, big,      16'd0, 1'b0, 1'b1);
    test_divide("edge_m32768", -26'sd32768,  15'd1, 27, 16'h8000, 16'd0, 1'b0, 1'b0);
    test_divide("edge_p32768", 26'd32768,    15'd1, 27, p32768,   16'd0, 1'b0, 1'b1);
    test_divide("edge_m32769", -26'sd32769,  15'd1, 27, m32769,   16'd0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(26'd77, 15'd5, lat);
    total++; if (lat !== 27) begin bad++; $display("FAIL bp_latency got=%0d want=27", lat); end
    // Offer new operands while the result is held; they must be ignored.
    din0 = 26'd9; din1 = 15'd3; din_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (dout !== 16'd15 || rem !== 16'd2 || din_rdy !== 1'b0 || dout_vld !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got dout=%0d rem=%0d rdy=%b vld=%b want 15 2 0 1", i, dout, rem, din_rdy, dout_vld);
      end
    end
    dout_rdy = 1'b1;
    @(posedge clk); #1;
    dout_rdy = 1'b0;
    din_vld  = 1'b0;
    total++; if (din_rdy !== 1'b1 || dout_vld !== 1'b0) begin bad++; $display("FAIL bp_release got rdy=%b vld=%b want 1 0", din_rdy, dout_vld); end
    @(posedge clk); #1;
    total++; if (din_rdy !== 1'b1) begin bad++; $display("FAIL bp_no_accept got rdy=%b want 1", din_rdy); end
  endtask

  task automatic test_reset_mid();
    din0 = 26'd1000; din1 = 15'd7; din_vld = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    ap_rst = 1'b1;
    @(posedge clk); #1;
    ap_rst = 1'b0;
    total++; if (dout_vld !== 1'b0 || din_rdy !== 1'b1) begin bad++; $display("FAIL rst_mid_state got vld=%b rdy=%b want 0 1", dout_vld, din_rdy); end
    total++; if (dout !== 16'h0 || rem !== 16'h0) begin bad++; $display("FAIL rst_mid_data got dout=%h rem=%h want 0 0", dout, rem); end
    test_divide("after_rst", 26'h2000000, 15'd32767, 27, 16'hFC00, 16'hFC00, 1'b0, 1'b0);
  endtask

  initial begin
    ap_rst   = 1'b1;
    din_vld  = 1'b0;
    din0     = '0;
    din1     = '0;
    dout_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ap_rst = 1'b0;

    test_reset();
    test_divide("pos",      26'd1000,    15'd7,   27, 16'd142,   16'd6,    1'b0, 1'b0);
    test_divide("neg",      -26'sd1000,  15'd7,   27, 16'hFF72,  16'hFFFA, 1'b0, 1'b0);
    test_divide("b2b_pos",  26'd12345,   15'd123, 27, 16'd100,   16'd45,   1'b0, 1'b0);
    test_divide("b2b_neg",  -26'sd12345, 15'd123, 27, 16'hFF9C,  16'hFFD3, 1'b0, 1'b0);
    test_divide("dbz_neg",  -26'sd5,     15'd0,   1,  16'h8000,  16'd0,    1'b1, 1'b0);
    test_divide("dbz_pos",  26'd123,     15'd0,   1,  16'h7FFF,  16'd0,    1'b1, 1'b0);
    test_overflow();
    test_backpressure();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
